// File: rtl/display_arb_pkg.sv
// Shared state encoding, widths and helper function for the display request arbiter.
package display_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BCD_W  = 12;

  // Ceiling log2 with a floor of 1 so single-value counters still get a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from pointer+1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_pointer,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_valid
);

  always_comb begin
    int unsigned j;
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = 32'(i_pointer) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!o_valid && i_req[j[IDX_W-1:0]]) begin
        o_valid              = 1'b1;
        o_index              = j[IDX_W-1:0];
        o_grant[j[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_request_arbiter.sv
// Shares the BCD converter + display path among NUM_REQ requesters (round-robin).
// Optional DISPLAY_ARB_PRIORITY_EN: requester 0 gets fixed priority and may cut HOLD short.
module display_request_arbiter
  import display_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned HOLD_CYCLES  = 100000,
  parameter int unsigned CONV_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      conv_start,
  output logic [DATA_W-1:0]         conv_binary,
  input  logic                      conv_eoc,
  input  logic [BCD_W-1:0]          conv_bcd,
  output logic [BCD_W-1:0]          disp_bcd,
  output logic                      disp_valid,
  output logic [2:0]                active_src,
  output logic                      timeout_err
);

  localparam int unsigned IDX_W   = clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > CONV_TIMEOUT) ? HOLD_CYCLES : CONV_TIMEOUT;
  localparam int unsigned CNT_W   = clog2(CNT_MAX);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_arb_grant, w_gnt_onehot;
  logic [IDX_W-1:0]   w_arb_index, w_gnt_idx;
  logic               w_arb_valid;
  logic [DATA_W-1:0]  w_gnt_data;
  logic               w_hold_abort;
  logic               w_take, w_start, w_cnt_clr, w_cnt_inc, w_eoc_take, w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req     (req),
    .i_pointer (r_ptr),
    .o_grant   (w_arb_grant),
    .o_index   (w_arb_index),
    .o_valid   (w_arb_valid)
  );

  always_comb begin
    w_gnt_onehot = w_arb_grant;
    w_gnt_idx    = w_arb_index;
`ifdef DISPLAY_ARB_PRIORITY_EN
    if (req[0]) begin
      w_gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1};
      w_gnt_idx    = '0;
    end
`endif
  end

`ifdef DISPLAY_ARB_PRIORITY_EN
  assign w_hold_abort = req[0];
`else
  assign w_hold_abort = 1'b0;
`endif

  always_comb begin
    w_gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (w_gnt_onehot[i]) w_gnt_data = req_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_start     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_eoc_take  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_take      = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_start     = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = CONVERT;
      end
      CONVERT: begin
        if (conv_eoc) begin
          w_eoc_take  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = HOLD;
        end else if (r_cnt == CNT_W'(CONV_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (w_hold_abort || r_cnt == CNT_W'(HOLD_CYCLES - 1)) w_state_nxt = IDLE;
        else                                                  w_cnt_inc   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // All outputs are registered off the FSM decision, so they trail the state by one edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      ack         <= '0;
      conv_start  <= 1'b0;
      timeout_err <= 1'b0;
      conv_binary <= '0;
      disp_bcd    <= '0;
      disp_valid  <= 1'b0;
      active_src  <= '0;
    end else begin
      ack         <= w_take ? w_gnt_onehot : '0;
      conv_start  <= w_start;
      timeout_err <= w_timeout;
      if (w_take) begin
        conv_binary <= w_gnt_data;
        r_ptr       <= w_gnt_idx;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_eoc_take) begin
        disp_bcd   <= conv_bcd;
        active_src <= 3'(r_ptr);
        disp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_request_arbiter.sv
// Directed self-checking bench for display_request_arbiter (NUM_REQ=4, HOLD=8, TIMEOUT=16).
module tb_display_request_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        conv_start;
  logic [7:0]  conv_binary;
  logic        conv_eoc = 1'b0;
  logic [11:0] conv_bcd = '0;
  logic [11:0] disp_bcd;
  logic        disp_valid;
  logic [2:0]  active_src;
  logic        timeout_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   eoc_en  = 1'b1;
  int   m_cnt   = 0;
  logic [7:0] m_bin = '0;

  display_request_arbiter #(
    .NUM_REQ      (4),
    .HOLD_CYCLES  (8),
    .CONV_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .conv_start  (conv_start),
    .conv_binary (conv_binary),
    .conv_eoc    (conv_eoc),
    .conv_bcd    (conv_bcd),
    .disp_bcd    (disp_bcd),
    .disp_valid  (disp_valid),
    .active_src  (active_src),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // Converter model: eoc pulse 5 cycles after a sampled start, unless disabled.
  always @(negedge clk) begin
    conv_eoc = 1'b0;
    if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        conv_eoc = 1'b1;
        conv_bcd = to_bcd(m_bin);
      end
    end
    if (conv_start && eoc_en) begin
      m_cnt = 5;
      m_bin = conv_binary;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [3:0] a, output int n);
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (ack != 4'b0) break;
    end
    a = ack;
    check_eq("ack_arrives", 32'(ack != 4'b0), 32'd1);
  endtask

  task automatic wait_eoc();
    int n;
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (conv_eoc) break;
    end
    check_eq("eoc_arrives", 32'(conv_eoc), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  a;
    int          n;
    logic [3:0]  exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0]  exp_bin [5] = '{8'd7, 8'd45, 8'd200, 8'd9, 8'd7};
    logic [11:0] exp_bcd [5] = '{12'h007, 12'h045, 12'h200, 12'h009, 12'h007};
    logic [2:0]  exp_src [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    bit          any_ack, any_start;

    // Reset values
    reset = 1'b0;
    repeat (3) tick();
    check_eq("rst_ack",     32'(ack),         32'h0);
    check_eq("rst_start",   32'(conv_start),  32'h0);
    check_eq("rst_tmo",     32'(timeout_err), 32'h0);
    check_eq("rst_valid",   32'(disp_valid),  32'h0);
    check_eq("rst_bin",     32'(conv_binary), 32'h0);
    check_eq("rst_bcd",     32'(disp_bcd),    32'h0);
    check_eq("rst_src",     32'(active_src),  32'h0);
    reset = 1'b1;
    tick();

    // Single request
    req_data[7:0] = 8'd123;
    req = 4'b0001;
    wait_ack(a, n);
    check_eq("t1_ack", 32'(a), 32'h1);
    check_eq("t1_bin", 32'(conv_binary), 32'd123);
    req = 4'b0000;
    tick();
    check_eq("t1_ack_pulse", 32'(ack), 32'h0);
    check_eq("t1_start", 32'(conv_start), 32'h1);
    tick();
    check_eq("t1_start_pulse", 32'(conv_start), 32'h0);
    wait_eoc();
    check_eq("t1_bcd",   32'(disp_bcd),   32'h123);
    check_eq("t1_src",   32'(active_src), 32'd0);
    check_eq("t1_valid", 32'(disp_valid), 32'd1);
    req = 4'b0001;
    wait_ack(a, n);
    check_eq("t1_hold_lat", 32'(n), 32'd9);
    check_eq("t1_ack2", 32'(a), 32'h1);
    req = 4'b0000;
    wait_eoc();
    check_eq("t1_bcd2", 32'(disp_bcd), 32'h123);

    // Reset mid-hold, then everybody requests
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    req_data = {8'd9, 8'd200, 8'd45, 8'd7};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(a, n);
      check_eq($sformatf("t2_ack%0d", i), 32'(a), 32'(exp_ack[i]));
      check_eq($sformatf("t2_bin%0d", i), 32'(conv_binary), 32'(exp_bin[i]));
      if (i > 0) check_eq($sformatf("t2_lat%0d", i), 32'(n), 32'd9);
      wait_eoc();
      check_eq($sformatf("t2_bcd%0d", i), 32'(disp_bcd), 32'(exp_bcd[i]));
      check_eq($sformatf("t2_src%0d", i), 32'(active_src), 32'(exp_src[i]));
    end
    req = 4'b0000;
    repeat (12) tick();

    // Conversion timeout
    eoc_en = 1'b0;
    req_data[15:8] = 8'd88;
    req = 4'b0010;
    wait_ack(a, n);
    check_eq("t3_ack", 32'(a), 32'h2);
    req = 4'b0000;
    tick();
    check_eq("t3_start", 32'(conv_start), 32'h1);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (timeout_err) break;
    end
    check_eq("t3_tmo_lat", 32'(n), 32'd16);
    tick();
    check_eq("t3_tmo_pulse", 32'(timeout_err), 32'h0);
    check_eq("t3_bcd_kept",  32'(disp_bcd),    32'h007);
    check_eq("t3_src_kept",  32'(active_src),  32'd0);
    check_eq("t3_valid",     32'(disp_valid),  32'd1);
    check_eq("t3_bin",       32'(conv_binary), 32'd88);
    eoc_en = 1'b1;
    req_data[23:16] = 8'd56;
    req = 4'b0100;
    wait_ack(a, n);
    check_eq("t3_next_ack", 32'(a), 32'h4);
    req = 4'b0000;
    wait_eoc();
    check_eq("t3_next_bcd", 32'(disp_bcd), 32'h056);
    check_eq("t3_next_src", 32'(active_src), 32'd2);
    repeat (12) tick();

    // Reset during CONVERT; the late eoc must be ignored
    req_data[7:0] = 8'd99;
    req = 4'b0001;
    wait_ack(a, n);
    check_eq("t4_ack", 32'(a), 32'h1);
    req = 4'b0000;
    tick();
    check_eq("t4_start", 32'(conv_start), 32'h1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (8) tick();
    check_eq("t4_ack0",   32'(ack),         32'h0);
    check_eq("t4_start0", 32'(conv_start),  32'h0);
    check_eq("t4_tmo0",   32'(timeout_err), 32'h0);
    check_eq("t4_bin0",   32'(conv_binary), 32'h0);
    check_eq("t4_bcd0",   32'(disp_bcd),    32'h0);
    check_eq("t4_valid0", 32'(disp_valid),  32'h0);
    check_eq("t4_src0",   32'(active_src),  32'h0);
    req_data = {8'd250, 8'd0, 8'd0, 8'd17};
    req = 4'b1001;
    wait_ack(a, n);
    check_eq("t4_rr_ack", 32'(a), 32'h1);
    check_eq("t4_rr_bin", 32'(conv_binary), 32'd17);
    req = 4'b0000;
    wait_eoc();
    check_eq("t4_bcd", 32'(disp_bcd), 32'h017);

    // Request withdrawn while in HOLD
    req = 4'b0010;
    tick();
    req = 4'b0000;
    any_ack   = 1'b0;
    any_start = 1'b0;
    repeat (25) begin
      tick();
      if (ack != 4'b0) any_ack = 1'b1;
      if (conv_start)  any_start = 1'b1;
    end
    check_eq("t5_no_ack",   32'(any_ack),   32'h0);
    check_eq("t5_no_start", 32'(any_start), 32'h0);
    check_eq("t5_bcd_kept", 32'(disp_bcd),  32'h017);

`ifdef DISPLAY_ARB_PRIORITY_EN
    req_data[23:16] = 8'd33;
    req = 4'b0100;
    wait_ack(a, n);
    req = 4'b0000;
    wait_eoc();
    check_eq("t6_src2", 32'(active_src), 32'd2);
    req_data[7:0] = 8'd255;
    req = 4'b0001;
    wait_ack(a, n);
    check_eq("t6_abort_lat", 32'(n), 32'd2);
    check_eq("t6_ack", 32'(a), 32'h1);
    req = 4'b0000;
    wait_eoc();
    check_eq("t6_bcd", 32'(disp_bcd), 32'h255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
